// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, byte-lane
// select constants and the default wait-state count.
package dmem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int CNT_W = 4;
    localparam int WAIT_CYCLES_DEF = 2;

    // Big-endian lane selects: byte offset 0 lives in data[31:24] / sel[3].
    localparam logic [3:0] SEL_B0 = 4'b1000;
    localparam logic [3:0] SEL_B1 = 4'b0100;
    localparam logic [3:0] SEL_B2 = 4'b0010;
    localparam logic [3:0] SEL_B3 = 4'b0001;
    localparam logic [3:0] SEL_H0 = 4'b1100;
    localparam logic [3:0] SEL_H1 = 4'b0011;
    localparam logic [3:0] SEL_W  = 4'b1111;

    // Expand a lane select into a 32-bit bit mask (lane n -> bits [8n+7:8n]).
    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        logic [31:0] mask;
        mask = '0;
        for (int n = 0; n < 4; n++) begin
            mask[8*n +: 8] = {8{sel[n]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of the data memory: 2^AW x 8-bit array, synchronous write,
// combinational read.
module dmem_bank #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:(1<<AW)-1];

    // NOTE: the array deliberately has no reset; contents survive rst and a
    // reset branch here would also stop the tool from mapping it onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder for the MEM stage: word array built from four byte
// banks, optional wait-state FSM enabled by the DMEM_WAIT_EN macro.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int AW          = 12,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        err_o
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("dmem_resp: WAIT_CYCLES must lie in 0..15");
    end

    logic [AW-1:0] word_addr;
    logic          out_of_range;
    logic          complete;
    logic          done;
    logic          store_en;
    logic          load_en;
    logic [31:0]   rdata_word;
    logic [31:0]   lane_mask;

    // Byte offset bits [1:0] never reach the word select; lanes come from sel_i.
    assign word_addr    = addr_i[AW+1:2];
    assign out_of_range = (addr_i >> (AW + 2)) != 32'd0;

`ifdef DMEM_WAIT_EN
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ce_i) begin
                    if (WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!ce_i) begin
                    // Initiator flushed the access: abandon it without side effects.
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign stall_o = stall;
`else
    assign stall_o  = 1'b0;
    assign complete = ce_i;
`endif

    // A completion that coincides with reset is dropped entirely.
    assign done     = complete && !rst;
    assign store_en = done && we_i && !out_of_range;
    assign load_en  = done && !we_i && !out_of_range;

    for (genvar n = 0; n < 4; n++) begin : g_lane
        dmem_bank #(
            .AW (AW)
        ) u_bank (
            .clk   (clk),
            .we    (store_en && sel_i[n]),
            .addr  (word_addr),
            .wdata (data_i[8*n +: 8]),
            .rdata (rdata_word[8*n +: 8])
        );
    end

    assign lane_mask = sel_to_mask(SEL_W);
    assign data_o    = load_en ? (rdata_word & lane_mask) : 32'd0;
    assign err_o     = done && out_of_range;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed scenarios plus a randomized
// load/store mix scored against a word-array reference model.
module tb_dmem_resp;

`ifdef DMEM_WAIT_EN
    localparam int WC = 2;
`else
    localparam int WC = 0;
`endif
    localparam int POOL = 16;
    localparam int BASE_WORD = 32'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        err_o;

    int vectors = 0;
    int fails   = 0;

    logic [31:0] model [POOL];

    dmem_resp #(
        .AW          (12),
        .WAIT_CYCLES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ce_i    (ce_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .sel_i   (sel_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .stall_o (stall_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access: stalls counted, then completion-cycle outputs checked.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int stalls;
        stalls = 0;
        ce_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; data_i = wdata;
        @(negedge clk);
        while (stall_o === 1'b1 && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        check($sformatf("%s stalls", tag), 32'(stalls), 32'(WC));
        check($sformatf("%s data", tag), data_o, we ? 32'd0 : exp_rdata);
        check($sformatf("%s err", tag), {31'd0, err_o}, {31'd0, exp_err});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        ce_i = 1'b0; we_i = 1'b0; sel_i = 4'h0; data_i = 32'd0;
        @(negedge clk);
        check($sformatf("%s idle", tag), {data_o[31:2], stall_o, err_o}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we, oor;
        logic [31:0] addr, wdata, exp;
        logic [3:0]  sel;
        int          idx;

        rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; sel_i = 4'h0; data_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset stall", {31'd0, stall_o}, 32'd0);
        check("reset data", data_o, 32'd0);
        check("reset err", {31'd0, err_o}, 32'd0);
        @(posedge clk);
        #1;

        // Full-word store then load of the same word.
        access("sw10", 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'd0, 1'b0);
        access("lw10", 1'b0, 32'h10, 4'b1111, 32'd0, 32'hDEADBEEF, 1'b0);
        // Byte store into offset 1 (sel[2], bits [23:16]).
        access("sb11", 1'b1, 32'h11, 4'b0100, 32'h55555555, 32'd0, 1'b0);
        access("lw10b", 1'b0, 32'h10, 4'b0001, 32'd0, 32'hDE55BEEF, 1'b0);
        // Byte offset bits are ignored for word selection.
        access("lw13", 1'b0, 32'h13, 4'b0000, 32'd0, 32'hDE55BEEF, 1'b0);
        // Empty lane select leaves the word unchanged.
        access("sw10z", 1'b1, 32'h10, 4'b0000, 32'h00000000, 32'd0, 1'b0);
        access("lw10z", 1'b0, 32'h10, 4'b1111, 32'd0, 32'hDE55BEEF, 1'b0);
        idle("after_lanes");

        // Flush after one stall cycle: store must not land.
        access("sw20", 1'b1, 32'h20, 4'b1111, 32'h0BADF00D, 32'd0, 1'b0);
`ifdef DMEM_WAIT_EN
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; sel_i = 4'b1111; data_i = 32'h12345678;
        @(negedge clk);
        check("flush stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk);
        #1;
        ce_i = 1'b0;
        @(negedge clk);
        check("flush err", {30'd0, stall_o, err_o}, 32'd0);
        @(posedge clk);
        #1;
`endif
        access("lw20", 1'b0, 32'h20, 4'b1111, 32'd0, 32'h0BADF00D, 1'b0);

        // Out-of-range store aliases word 0 in the low bits but must not write it.
        access("sw0", 1'b1, 32'h0, 4'b1111, 32'h11223344, 32'd0, 1'b0);
        access("sw_oor", 1'b1, 32'h00004000, 4'b1111, 32'hFFFFFFFF, 32'd0, 1'b1);
        idle("after_oor");
        access("lw0", 1'b0, 32'h0, 4'b1111, 32'd0, 32'h11223344, 1'b0);
        access("lw_oor", 1'b0, 32'h00004000, 4'b1111, 32'd0, 32'd0, 1'b1);
        idle("after_lw_oor");

        // Back-to-back store then load of the same word.
        access("sw8", 1'b1, 32'h8, 4'b1111, 32'hCAFEF00D, 32'd0, 1'b0);
        access("lw8", 1'b0, 32'h8, 4'b1111, 32'd0, 32'hCAFEF00D, 1'b0);

        // Reset during an in-flight store: word keeps its earlier value.
        access("sw30", 1'b1, 32'h30, 4'b1111, 32'h01020304, 32'd0, 1'b0);
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h30; sel_i = 4'b1111; data_i = 32'hFFFFFFFF;
`ifdef DMEM_WAIT_EN
        @(posedge clk);
        #1;
`endif
        rst = 1'b1;
        @(negedge clk);
        check("rst err", {31'd0, err_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; ce_i = 1'b0;
        @(negedge clk);
        check("post_rst stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        access("lw30", 1'b0, 32'h30, 4'b1111, 32'd0, 32'h01020304, 1'b0);

        // Randomized mix over a small word pool, scored against the model.
        for (int i = 0; i < POOL; i++) begin
            model[i] = $urandom;
            access("init", 1'b1, (BASE_WORD + i) << 2, 4'b1111, model[i], 32'd0, 1'b0);
        end
        for (int k = 0; k < 150; k++) begin
            we    = 1'($urandom_range(0, 1));
            idx   = $urandom_range(0, POOL - 1);
            oor   = ($urandom_range(0, 7) == 0);
            sel   = 4'($urandom_range(0, 15));
            wdata = $urandom;
            addr  = ((BASE_WORD + idx) << 2) | 32'($urandom_range(0, 3));
            if (oor) addr = addr | (32'd1 << $urandom_range(14, 31));
            exp = oor ? 32'd0 : model[idx];
            access($sformatf("rnd%0d", k), we, addr, sel, wdata, exp, oor);
            if (we && !oor) begin
                for (int n = 0; n < 4; n++) begin
                    if (sel[n]) model[idx][8*n +: 8] = wdata[8*n +: 8];
                end
            end
            if ($urandom_range(0, 3) == 0) idle($sformatf("rnd%0d", k));
        end
        for (int i = 0; i < POOL; i++) begin
            access($sformatf("final%0d", i), 1'b0, (BASE_WORD + i) << 2, 4'b1111, 32'd0, model[i], 1'b0);
        end
        idle("end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
